// File: rtl/cd_rx_ram_pkg.sv
// Shared constants and a byte-lane helper for the cd_* receive and transmit page RAMs.
package cd_rx_ram_pkg;

  localparam int CD_PAGE_BYTES = 256;
  localparam int CD_WORD_AW    = 6;
  localparam int CD_LANES      = 4;

  // Return word with byte lane 'lane' replaced by 'b'.
  function automatic logic [31:0] cd_merge_lane(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    r[lane*8 +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/cd_spram.sv
// Single-port synchronous RAM with active-low chip and write enables.
// The read register updates only on a read access.
module cd_spram #(
  parameter int A_WIDTH = 6,
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               cen,
  input  logic               wen,
  input  logic [A_WIDTH-1:0] addr,
  input  logic [D_WIDTH-1:0] d,
  output logic [D_WIDTH-1:0] q
);

  logic [D_WIDTH-1:0] mem_q [2**A_WIDTH];

  // NOTE: the storage array and read register are deliberately not reset; a
  // reset would force the array into flops instead of a RAM macro.
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!cen) begin
      if (!wen) mem_q[addr] <= d;
      else      q <= mem_q[addr];
    end
  end

endmodule

// File: rtl/cd_rx_ram.sv
// Receive frame buffer: a ring of 256-byte pages filled bytewise by the bus
// RX engine and read as 32-bit words by the host.
module cd_rx_ram
  import cd_rx_ram_pkg::*;
#(
  parameter int PAGE_NUM = 4,
  parameter int A_WIDTH  = CD_WORD_AW
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [7:0]         wr_byte,
  input  logic [7:0]         wr_addr,
  input  logic               wr_en,
  input  logic               wr_done,
  input  logic               wr_drop,
  output logic [31:0]        rd_word,
  input  logic [A_WIDTH-1:0] rd_addr,
  input  logic               rd_en,
  input  logic               rd_done,
  output logic               unread,
  output logic               rx_lost
);

  localparam int SW = (PAGE_NUM > 1) ? $clog2(PAGE_NUM) : 1;
  typedef logic [SW-1:0] sel_t;

  sel_t                wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d, rd_mux_q, rd_mux_d;
  sel_t                wr_sel_nxt, rd_sel_nxt;
  logic [PAGE_NUM-1:0] dirty_q, dirty_d;
  logic [31:0]         stage_q, stage_d;
  logic                pend_q, pend_d;
  logic [A_WIDTH-1:0]  waddr_q, waddr_d;
  logic                rx_lost_q, rx_lost_d;

  logic [31:0]         merged;
  logic [A_WIDTH-1:0]  flush_addr;
  logic                lane3, commit_req, ring_full, release_pg, wr_we;
  logic [31:0]         page_q [PAGE_NUM];

  assign wr_sel_nxt = wr_sel_q + 1'b1;
  assign rd_sel_nxt = rd_sel_q + 1'b1;
  assign lane3      = wr_en && (wr_addr[1:0] == 2'd3);
  assign commit_req = wr_done && !wr_drop;
  assign ring_full  = dirty_q[wr_sel_nxt];
  assign release_pg = rd_done && dirty_q[rd_sel_q];

  // A lane-3 byte completes a word; a commit flushes whatever partial word is staged.
  assign wr_we = lane3 || (commit_req && (pend_q || wr_en));

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    merged     = stage_q;
    flush_addr = waddr_q;
    if (wr_en) begin
      merged     = cd_merge_lane(stage_q, wr_addr[1:0], wr_byte);
      flush_addr = wr_addr[7:2];
    end

    stage_d = stage_q;
    pend_d  = pend_q;
    waddr_d = waddr_q;
    if (wr_en) waddr_d = wr_addr[7:2];
    if (wr_drop || wr_done || lane3) begin
      stage_d = '0;
      pend_d  = 1'b0;
    end else if (wr_en) begin
      stage_d = merged;
      pend_d  = 1'b1;
    end

    // Both ends see pre-clock dirty bits; the writer page is never dirty, so
    // the set and clear below cannot target the same page.
    dirty_d   = dirty_q;
    wr_sel_d  = wr_sel_q;
    rd_sel_d  = rd_sel_q;
    rx_lost_d = commit_req && ring_full;
    if (commit_req && !ring_full) begin
      dirty_d[wr_sel_q] = 1'b1;
      wr_sel_d          = wr_sel_nxt;
    end
    if (release_pg) begin
      dirty_d[rd_sel_q] = 1'b0;
      rd_sel_d          = rd_sel_nxt;
    end

    rd_mux_d = rd_en ? rd_sel_q : rd_mux_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_sel_q  <= '0;
      rd_sel_q  <= '0;
      rd_mux_q  <= '0;
      dirty_q   <= '0;
      stage_q   <= '0;
      pend_q    <= 1'b0;
      waddr_q   <= '0;
      rx_lost_q <= 1'b0;
    end else begin
      wr_sel_q  <= wr_sel_d;
      rd_sel_q  <= rd_sel_d;
      rd_mux_q  <= rd_mux_d;
      dirty_q   <= dirty_d;
      stage_q   <= stage_d;
      pend_q    <= pend_d;
      waddr_q   <= waddr_d;
      rx_lost_q <= rx_lost_d;
    end
  end

  for (genvar i = 0; i < PAGE_NUM; i++) begin : g_page
    logic wr_hit, rd_hit;
    assign wr_hit = wr_we && (wr_sel_q == sel_t'(i));
    assign rd_hit = rd_en && (rd_sel_q == sel_t'(i));

    cd_spram #(
      .A_WIDTH(A_WIDTH),
      .D_WIDTH(32)
    ) u_spram (
      .clk (clk),
      .cen (!(wr_hit || rd_hit)),
      .wen (!wr_hit),
      .addr(wr_hit ? flush_addr : rd_addr),
      .d   (merged),
      .q   (page_q[i])
    );
  end

  assign rd_word = page_q[rd_mux_q];
  assign unread  = dirty_q[rd_sel_q];
  assign rx_lost = rx_lost_q;

endmodule

// File: tb/tb_cd_rx_ram.sv
// Self-checking bench for cd_rx_ram: directed corner cases plus random frames
// compared against a FIFO-of-frames reference model.
module tb_cd_rx_ram;

  localparam int PAGE_NUM = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  wr_byte = '0;
  logic [7:0]  wr_addr = '0;
  logic        wr_en = 1'b0, wr_done = 1'b0, wr_drop = 1'b0;
  logic [31:0] rd_word;
  logic [5:0]  rd_addr = '0;
  logic        rd_en = 1'b0, rd_done = 1'b0;
  logic        unread, rx_lost;

  int total = 0;
  int bad   = 0;

  // Reference model: committed frames in arrival order, plus the frame in progress.
  logic [7:0] fr_mem [PAGE_NUM][256];
  int         fr_len [PAGE_NUM];
  int         head = 0, count = 0;
  logic [7:0] cur [256];
  int         cur_len = 0;

  cd_rx_ram #(.PAGE_NUM(PAGE_NUM)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_byte(wr_byte), .wr_addr(wr_addr), .wr_en(wr_en),
    .wr_done(wr_done), .wr_drop(wr_drop),
    .rd_word(rd_word), .rd_addr(rd_addr), .rd_en(rd_en), .rd_done(rd_done),
    .unread(unread), .rx_lost(rx_lost)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL timeout: simulation still running (required: finish)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push();
    int s;
    s = (head + count) % PAGE_NUM;
    for (int i = 0; i < 256; i++) fr_mem[s][i] = cur[i];
    fr_len[s] = cur_len;
    count++;
  endtask

  task automatic pop();
    head = (head + 1) % PAGE_NUM;
    count--;
  endtask

  function automatic logic [31:0] exp_word(input int a);
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < 4; b++)
      if (4 * a + b < fr_len[head]) w[b*8 +: 8] = fr_mem[head][4*a+b];
    return w;
  endfunction

  // Frame-end cycle; wr_en may already be driven by the caller for the last byte.
  task automatic end_cycle(input bit done, input bit drop, input bit rel);
    bit lost;
    int pre;
    wr_done = done; wr_drop = drop; rd_done = rel;
    pre  = count;
    lost = 1'b0;
    if (rel && count > 0) pop();
    if (done && !drop) begin
      if (pre < PAGE_NUM - 1) push();
      else lost = 1'b1;
    end
    tick();
    wr_en = 1'b0; wr_done = 1'b0; wr_drop = 1'b0; rd_done = 1'b0;
    check("rx_lost", 32'(rx_lost), 32'(lost));
    check("unread", 32'(unread), 32'(count > 0));
    tick();
    check("rx_lost_pulse", 32'(rx_lost), 32'd0);
  endtask

  task automatic send(input int len, input bit coinc, input bit drop, input bit rel);
    cur_len = len;
    for (int i = 0; i < len; i++) begin
      wr_byte = cur[i]; wr_addr = 8'(i); wr_en = 1'b1;
      if (coinc && i == len - 1) end_cycle(!drop, drop, rel);
      else tick();
    end
    wr_en = 1'b0;
    if (!coinc) end_cycle(!drop, drop, rel);
  endtask

  task automatic read_word(input int a, input bit rel, output logic [31:0] got);
    logic [31:0] exp;
    rd_addr = 6'(a); rd_en = 1'b1; rd_done = rel;
    exp = exp_word(a);
    if (rel && count > 0) pop();
    tick();
    rd_en = 1'b0; rd_done = 1'b0;
    got = rd_word;
    check("rd_word", rd_word, exp);
  endtask

  task automatic read_all();
    logic [31:0] g;
    for (int a = 0; a < (fr_len[head] + 3) / 4; a++) read_word(a, 1'b0, g);
  endtask

  task automatic release_page();
    rd_done = 1'b1;
    if (count > 0) pop();
    tick();
    rd_done = 1'b0;
    check("unread_rel", 32'(unread), 32'(count > 0));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    wr_en = 1'b0; wr_done = 1'b0; wr_drop = 1'b0; rd_en = 1'b0; rd_done = 1'b0;
    #2;
    check("rst_unread", 32'(unread), 32'd0);
    check("rst_rx_lost", 32'(rx_lost), 32'd0);
    head = 0; count = 0;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic fill_seq(input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++) cur[i] = base + 8'(i);
  endtask

  initial begin
    logic [31:0] g;
    #12;
    do_reset();

    // Basic frame: two full words.
    fill_seq(8, 8'h01);
    send(8, 1'b0, 1'b0, 1'b0);
    check("t1_unread", 32'(unread), 32'd1);
    read_word(0, 1'b0, g); check("t1_w0_lit", g, 32'h04030201);
    read_word(1, 1'b0, g); check("t1_w1_lit", g, 32'h08070605);
    release_page();

    // Partial last word flushed by a separate and by a coincident wr_done.
    fill_seq(5, 8'hA0);
    send(5, 1'b0, 1'b0, 1'b0);
    read_word(1, 1'b0, g); check("t2_w1_lit", g, 32'h000000A4);
    release_page();
    fill_seq(3, 8'hC0);
    send(3, 1'b1, 1'b0, 1'b0);
    read_word(0, 1'b0, g); check("t2_c_lit", g, 32'h00C2C1C0);
    release_page();

    // Ring full: fourth commit is lost, retried commit after a release succeeds.
    for (int f = 0; f < PAGE_NUM; f++) begin
      fill_seq(6 + f, 8'(8'h10 * (f + 1)));
      send(6 + f, 1'b0, 1'b0, 1'b0);
    end
    release_page();
    end_cycle(1'b1, 1'b0, 1'b0);
    while (count > 0) begin read_all(); release_page(); end

    // Drop, then a short frame must show no stale bytes.
    for (int i = 0; i < 12; i++) cur[i] = 8'hFF;
    send(12, 1'b0, 1'b1, 1'b0);
    check("t4_unread", 32'(unread), 32'd0);
    fill_seq(5, 8'h50);
    send(5, 1'b0, 1'b0, 1'b0);
    read_word(0, 1'b0, g); check("t4_w0_lit", g, 32'h53525150);
    read_word(1, 1'b0, g); check("t4_w1_lit", g, 32'h00000054);
    release_page();

    // rd_done coincident with rd_en keeps the old page's data.
    fill_seq(4, 8'h60); send(4, 1'b0, 1'b0, 1'b0);
    fill_seq(4, 8'h70); send(4, 1'b0, 1'b0, 1'b0);
    read_word(0, 1'b1, g); check("t5_old_lit", g, 32'h63626160);
    check("t5_unread", 32'(unread), 32'd1);
    read_word(0, 1'b0, g); check("t5_next_lit", g, 32'h73727170);
    release_page();

    // Full ring with coincident wr_done/rd_done: still lost, then retry commits.
    for (int f = 0; f < PAGE_NUM - 1; f++) begin
      fill_seq(7, 8'(8'h80 + 8'h10 * f));
      send(7, 1'b0, 1'b0, 1'b0);
    end
    fill_seq(9, 8'hB0);
    send(9, 1'b0, 1'b0, 1'b1);
    end_cycle(1'b1, 1'b0, 1'b0);
    while (count > 0) begin read_all(); release_page(); end

    // Reset mid-frame, then a clean frame from page 0.
    fill_seq(2, 8'hD0); send(2, 1'b0, 1'b0, 1'b0);
    fill_seq(3, 8'hE0);
    for (int i = 0; i < 3; i++) begin
      wr_byte = cur[i]; wr_addr = 8'(i); wr_en = 1'b1; tick();
    end
    do_reset();
    fill_seq(6, 8'h30); send(6, 1'b0, 1'b0, 1'b0);
    read_all(); release_page();

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      int  len;
      bit  drop, coinc, rel;
      len   = $urandom_range(1, 128);
      drop  = ($urandom_range(0, 7) == 0);
      coinc = $urandom_range(0, 1) == 1;
      rel   = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < len; i++) cur[i] = 8'($urandom);
      send(len, coinc, drop, rel);
      if (count > 0 && $urandom_range(0, 2) != 0) begin
        read_all();
        if ($urandom_range(0, 1) == 1) read_word(0, 1'b1, g);
        else release_page();
      end
    end
    while (count > 0) begin read_all(); release_page(); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
